reqsw_nch: RTL and testbench
============================

// Module: reqsw_nch
// PURPOSE
// N-client request/ack switch between one upstream link (ethernet/ipv4/udp/icmp layer) and N client protocol
// blocks. Arbitrates client requests into a request FIFO; returns upstream acks to the owning client; muxes client tx data up.
// Replaces fixed 1/2-client switches: parametrised client count, arbitration mode, backpressure, owner-index ack routing.
// PARAMETERS
// NCH    2   number of clients, 1..16
// CW     16  request/ack code width
// DW     8   tx data width per client
// AW     5   request FIFO address width, depth 2**AW
// RRMODE 0   0 = fixed priority (index 0 highest), 1 = round robin
// PORTS
// clk            in   1        single clock
// reset          in   1        synchronous, active-high
// cl_request     in   NCH      per-client request pulse, 1 cycle per request
// cl_requestcode in   NCH*CW   per-client code, slice i = [i*CW +: CW]
// cl_requestacpt out  NCH      request of client i accepted this cycle
// cl_ack         out  NCH      one-cycle ack to owning client
// cl_ackcode     out  CW       code of current ack, shared by all clients
// cl_txsrc       in   NCH*DW   client tx data
// up_request_w   out  1        pulse per accepted request, to upstream
// up_ack         in   1        upstream grant, pops one FIFO entry
// up_ackcode     out  CW       = cl_ackcode
// up_txdst       out  DW       tx data of current owner
// reqcnt         out  AW+1     FIFO occupancy
// ovf_err        out  1        sticky: up_ack while FIFO empty
// BEHAVIOUR
// - Reset: outputs 0, FIFO empty, reqcnt 0, RR pointer 0, ovf_err 0, owner index 0.
// - Arbitration, comb: grant = at most one client among cl_request; cl_requestacpt = one-hot grant & ~full.
//   RRMODE=0: lowest set index wins. RRMODE=1: search starts at ptr; ptr <= winner+1 (mod NCH) on accepted grant.
//   Ungranted/blocked requests are dropped, not held; client must re-request (acpt low tells it).
// - Push: accepted grant writes {idx,code} to FIFO same edge; up_request_w = push, comb.
// - Full: no push, all cl_requestacpt 0, RR ptr unchanged. Push and pop in same cycle when full: pop
//   only, push refused (full evaluated before pop).
// - Pop: up_ack & ~empty pops at edge t; FIFO dout valid during t+1 (registered read);
//   at edge t+1 register owner idx, ackcode, ackv; cl_ack[idx] = ackv, high in cycle t+2 only.
// - Back-to-back up_ack: one ack per cycle, in FIFO order. up_ack while empty: no pop, ovf_err <= 1.
// - cl_ackcode/up_ackcode/owner idx hold last value until next valid pop.
// - up_txdst = cl_txsrc slice[owner idx], comb; owner idx >= NCH impossible.
// - reqcnt: +1 push, -1 pop, unchanged when both or neither; range 0..2**AW, never wraps.
// - Reset mid-operation: FIFO flushed, pending acks lost, pulses in reset cycle ignored.
// - Widths: idx field = $clog2(NCH) (min 1); FIFO width = idx+CW.
// STRUCTURE
// - Package reqsw_pkg: ARB_FIXED=0, ARB_RR=1 constants; function idxw(n) returning max(1,$clog2(n)).
// - Sub-module reqsw_fifo: sync FIFO, params AW/W, registered read, doutvalid, full, empty, count.
// - Top: arbiter comb + RR pointer reg, ack/owner regs, tx mux, ovf_err.
// TESTING
// 1 NCH=3,RRMODE=0: cl_request=3'b111 one cycle -> cl_requestacpt=3'b001, one push, reqcnt=1.
// 2 RRMODE=1: cl_request=3'b111 for 3 cycles -> grants 0,1,2; then up_ack x3 -> cl_ack 001,010,100
//   in cycles t+2,t+3,t+4 with matching codes.
// 3 AW=2: push 4 -> reqcnt=4, 5th request acpt=0; push+up_ack same cycle when full -> reqcnt=3.
// 4 code 16'h0800 from client 1, 16'h0806 from client 0 -> acks routed by idx not code; up_txdst
//   switches to cl_txsrc[1] after first ack, holds until next.
// 5 up_ack with empty FIFO -> no cl_ack, ovf_err=1 sticky until reset.
// 6 reset asserted with 3 entries queued, up_ack high -> reqcnt=0, no cl_ack, ackcode=0 next cycle.

Source files
------------

// File: rtl/reqsw_nch_pkg.sv
// Shared constants and helpers for the N-client request/ack switch.
// Imported by the switch top and its request FIFO.
package reqsw_nch_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Width of the owner-index field; a single client still needs one bit.
   function automatic int idxw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reqsw_nch_if.sv
// Client/upstream handshake bundle of the request/ack switch.
// The switch uses the slave view; the surrounding logic drives the master view.
interface reqsw_nch_if #(
   parameter int NCH = 2,
   parameter int CW  = 16,
   parameter int DW  = 8,
   parameter int AW  = 5
);
   logic [NCH-1:0]    cl_request;
   logic [NCH*CW-1:0] cl_requestcode;
   logic [NCH-1:0]    cl_requestacpt;
   logic [NCH-1:0]    cl_ack;
   logic [CW-1:0]     cl_ackcode;
   logic [NCH*DW-1:0] cl_txsrc;
   logic              up_request_w;
   logic              up_ack;
   logic [CW-1:0]     up_ackcode;
   logic [DW-1:0]     up_txdst;
   logic [AW:0]       reqcnt;
   logic              ovf_err;

   modport slave (
      input  cl_request, cl_requestcode, cl_txsrc, up_ack,
      output cl_requestacpt, cl_ack, cl_ackcode, up_request_w,
             up_ackcode, up_txdst, reqcnt, ovf_err
   );

   modport master (
      output cl_request, cl_requestcode, cl_txsrc, up_ack,
      input  cl_requestacpt, cl_ack, cl_ackcode, up_request_w,
             up_ackcode, up_txdst, reqcnt, ovf_err
   );
endinterface

// File: rtl/reqsw_nch_fifo.sv
// Synchronous request FIFO with a registered read port: a pop at one edge
// presents its entry on dout_o, qualified by doutvalid_o, for the following cycle.
module reqsw_nch_fifo #(
   parameter int AW = 5,
   parameter int W  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         doutvalid_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o
);
   localparam int DEPTH = 1 << AW;

   logic [W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]   wrPtr_q, rdPtr_q;
   logic [AW:0]     count_q, count_d;
   logic [W-1:0]    dout_q;
   logic            doutValid_q;
   logic            pushOk, popOk;

   assign full_o      = (count_q == (AW+1)'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign pushOk      = push_i & ~full_o;
   assign popOk       = pop_i & ~empty_o;
   assign dout_o      = dout_q;
   assign doutvalid_o = doutValid_q;
   assign count_o     = count_q;

   always_comb begin
      count_d = count_q;
      if (pushOk && !popOk) begin
         count_d = count_q + 1'b1;
      end else if (!pushOk && popOk) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage carries no reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem_q[wrPtr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         doutValid_q <= 1'b0;
      end else begin
         if (pushOk) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (popOk) begin
            rdPtr_q <= rdPtr_q + 1'b1;
            dout_q  <= mem_q[rdPtr_q];
         end
         doutValid_q <= popOk;
         count_q     <= count_d;
      end
   end
endmodule

// File: rtl/reqsw_nch.sv
// N-client request/ack switch: arbitrates client requests into a FIFO, routes
// upstream acks back to the owning client and muxes the owner's tx data upstream.
module reqsw_nch
   import reqsw_nch_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int CW     = 16,
   parameter int DW     = 8,
   parameter int AW     = 5,
   parameter int RRMODE = 0
) (
   input  logic clk,
   input  logic reset,
   reqsw_nch_if.slave bus
);
   localparam int IW = idxw(NCH);
   localparam int FW = IW + CW;

   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  winner;
   logic           anyReq;
   logic [NCH-1:0] grant;
   logic           push, pop;
   logic           fifoFull, fifoEmpty, fifoDoutValid;
   logic [FW-1:0]  fifoDin, fifoDout;
   logic [AW:0]    fifoCount;

   logic [IW-1:0]  owner_q, owner_d;
   logic [CW-1:0]  ackCode_q, ackCode_d;
   logic           ackValid_q, ackValid_d;
   logic           ovfErr_q, ovfErr_d;
   logic [NCH-1:0] clAck;

   // Scan clients starting at the RR pointer (or index 0 in fixed mode);
   // the first requester found wins and everyone else is simply dropped.
   always_comb begin
      int cand;
      cand   = 0;
      anyReq = 1'b0;
      winner = '0;
      grant  = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = ((RRMODE == ARB_RR) ? int'(ptr_q) : 0) + k;
         if (cand >= NCH) begin
            cand = cand - NCH;
         end
         if (!anyReq && bus.cl_request[cand[IW-1:0]]) begin
            anyReq = 1'b1;
            winner = cand[IW-1:0];
         end
      end
      if (anyReq && !reset) begin
         grant[winner] = 1'b1;
      end
   end

   assign push    = (|grant) & ~fifoFull;
   assign pop     = bus.up_ack & ~fifoEmpty;
   assign fifoDin = {winner, bus.cl_requestcode[winner*CW +: CW]};

   assign bus.cl_requestacpt = fifoFull ? '0 : grant;
   assign bus.up_request_w   = push;

   always_comb begin
      ptr_d = ptr_q;
      if (push && (RRMODE == ARB_RR)) begin
         ptr_d = (winner == IW'(NCH - 1)) ? '0 : winner + 1'b1;
      end
   end

   reqsw_nch_fifo #(
      .AW (AW),
      .W  (FW)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .din_i       (fifoDin),
      .pop_i       (pop),
      .dout_o      (fifoDout),
      .doutvalid_o (fifoDoutValid),
      .full_o      (fifoFull),
      .empty_o     (fifoEmpty),
      .count_o     (fifoCount)
   );

   // Owner and code only move on a valid FIFO read so they hold between acks.
   always_comb begin
      owner_d    = owner_q;
      ackCode_d  = ackCode_q;
      ackValid_d = fifoDoutValid;
      ovfErr_d   = ovfErr_q | (bus.up_ack & fifoEmpty);
      if (fifoDoutValid) begin
         owner_d   = fifoDout[FW-1 -: IW];
         ackCode_d = fifoDout[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         owner_q    <= '0;
         ackCode_q  <= '0;
         ackValid_q <= 1'b0;
         ovfErr_q   <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         ackCode_q  <= ackCode_d;
         ackValid_q <= ackValid_d;
         ovfErr_q   <= ovfErr_d;
      end
   end

   always_comb begin
      clAck = '0;
      if (ackValid_q) begin
         clAck[owner_q] = 1'b1;
      end
   end

   assign bus.cl_ack     = clAck;
   assign bus.cl_ackcode = ackCode_q;
   assign bus.up_ackcode = ackCode_q;
   assign bus.up_txdst   = bus.cl_txsrc[owner_q*DW +: DW];
   assign bus.reqcnt     = fifoCount;
   assign bus.ovf_err    = ovfErr_q;
endmodule

// File: tb/tb_reqsw_nch.sv
// Directed bench for reqsw_nch: a fixed-priority 4-deep instance (A) and a
// round-robin 32-deep instance (B), both with three clients.
module tb_reqsw_nch;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   reqsw_nch_if #(.NCH(3), .CW(16), .DW(8), .AW(2)) ifA ();
   reqsw_nch_if #(.NCH(3), .CW(16), .DW(8), .AW(5)) ifB ();

   reqsw_nch #(.NCH(3), .CW(16), .DW(8), .AW(2), .RRMODE(0)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (ifA.slave)
   );

   reqsw_nch #(.NCH(3), .CW(16), .DW(8), .AW(5), .RRMODE(1)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (ifB.slave)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; outputs are read before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] req, input logic ack);
      ifA.cl_request = req;
      ifA.up_ack     = ack;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (ifA.reqcnt !== 3'd0) begin errors++; $display("[TB] FAIL rst_reqcntA got %0d exp 0", ifA.reqcnt); end
      checks++; if (ifB.reqcnt !== 6'd0) begin errors++; $display("[TB] FAIL rst_reqcntB got %0d exp 0", ifB.reqcnt); end
      checks++; if (ifA.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got %b exp 0", ifA.ovf_err); end
      checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL rst_clack got %b exp 000", ifA.cl_ack); end
      checks++; if (ifA.cl_ackcode !== 16'h0000) begin errors++; $display("[TB] FAIL rst_ackcode got %h exp 0000", ifA.cl_ackcode); end
      checks++; if (ifA.up_request_w !== 1'b0) begin errors++; $display("[TB] FAIL rst_upreq got %b exp 0", ifA.up_request_w); end
   endtask

   task automatic test_fixed_priority();
      ifA.cl_requestcode = {16'h3332, 16'h2221, 16'h1110};
      applyStimulus(3'b111, 1'b0);
      checks++; if (ifA.cl_requestacpt !== 3'b001) begin errors++; $display("[TB] FAIL fp_acpt got %b exp 001", ifA.cl_requestacpt); end
      checks++; if (ifA.up_request_w !== 1'b1) begin errors++; $display("[TB] FAIL fp_upreq got %b exp 1", ifA.up_request_w); end
      tick();
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.reqcnt !== 3'd1) begin errors++; $display("[TB] FAIL fp_reqcnt got %0d exp 1", ifA.reqcnt); end
      applyStimulus(3'b000, 1'b1);
      tick();
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL fp_ack_early got %b exp 000", ifA.cl_ack); end
      tick();
      checks++; if (ifA.cl_ack !== 3'b001) begin errors++; $display("[TB] FAIL fp_ack got %b exp 001", ifA.cl_ack); end
      checks++; if (ifA.cl_ackcode !== 16'h1110) begin errors++; $display("[TB] FAIL fp_ackcode got %h exp 1110", ifA.cl_ackcode); end
      checks++; if (ifA.up_ackcode !== 16'h1110) begin errors++; $display("[TB] FAIL fp_upackcode got %h exp 1110", ifA.up_ackcode); end
      tick();
      checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL fp_ack_once got %b exp 000", ifA.cl_ack); end
      checks++; if (ifA.reqcnt !== 3'd0) begin errors++; $display("[TB] FAIL fp_reqcnt_end got %0d exp 0", ifA.reqcnt); end
   endtask

   task automatic test_round_robin();
      logic [2:0]  expAcpt [3];
      logic [15:0] expCode [3];
      expAcpt = '{3'b001, 3'b010, 3'b100};
      expCode = '{16'hA000, 16'hB001, 16'hC002};
      ifB.cl_requestcode = {16'hC002, 16'hB001, 16'hA000};
      ifB.cl_request = 3'b111;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (ifB.cl_requestacpt !== expAcpt[i]) begin errors++; $display("[TB] FAIL rr_acpt%0d got %b exp %b", i, ifB.cl_requestacpt, expAcpt[i]); end
         tick();
      end
      ifB.cl_request = 3'b000;
      #1;
      checks++; if (ifB.reqcnt !== 6'd3) begin errors++; $display("[TB] FAIL rr_reqcnt got %0d exp 3", ifB.reqcnt); end
      ifB.up_ack = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) ifB.up_ack = 1'b0;
         #1;
         checks++; if (ifB.cl_ack !== expAcpt[i]) begin errors++; $display("[TB] FAIL rr_ack%0d got %b exp %b", i, ifB.cl_ack, expAcpt[i]); end
         checks++; if (ifB.cl_ackcode !== expCode[i]) begin errors++; $display("[TB] FAIL rr_code%0d got %h exp %h", i, ifB.cl_ackcode, expCode[i]); end
         tick();
      end
      checks++; if (ifB.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL rr_ack_end got %b exp 000", ifB.cl_ack); end
      checks++; if (ifB.reqcnt !== 6'd0) begin errors++; $display("[TB] FAIL rr_reqcnt_end got %0d exp 0", ifB.reqcnt); end
      ifB.cl_request = 3'b111;
      #1;
      checks++; if (ifB.cl_requestacpt !== 3'b001) begin errors++; $display("[TB] FAIL rr_wrap got %b exp 001", ifB.cl_requestacpt); end
      ifB.cl_request = 3'b000;
      #1;
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         ifA.cl_requestcode = {16'h0000, 16'h0000, 16'h0010 + 16'(i)};
         applyStimulus(3'b001, 1'b0);
         tick();
      end
      checks++; if (ifA.reqcnt !== 3'd4) begin errors++; $display("[TB] FAIL full_reqcnt got %0d exp 4", ifA.reqcnt); end
      ifA.cl_requestcode = {16'h0000, 16'h0000, 16'h0014};
      #1;
      checks++; if (ifA.cl_requestacpt !== 3'b000) begin errors++; $display("[TB] FAIL full_acpt got %b exp 000", ifA.cl_requestacpt); end
      checks++; if (ifA.up_request_w !== 1'b0) begin errors++; $display("[TB] FAIL full_upreq got %b exp 0", ifA.up_request_w); end
      tick();
      checks++; if (ifA.reqcnt !== 3'd4) begin errors++; $display("[TB] FAIL full_hold got %0d exp 4", ifA.reqcnt); end
      applyStimulus(3'b100, 1'b1);
      checks++; if (ifA.cl_requestacpt !== 3'b000) begin errors++; $display("[TB] FAIL full_pushpop_acpt got %b exp 000", ifA.cl_requestacpt); end
      tick();
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.reqcnt !== 3'd3) begin errors++; $display("[TB] FAIL full_pushpop got %0d exp 3", ifA.reqcnt); end
      tick();
      checks++; if (ifA.cl_ack !== 3'b001) begin errors++; $display("[TB] FAIL full_ack got %b exp 001", ifA.cl_ack); end
      checks++; if (ifA.cl_ackcode !== 16'h0010) begin errors++; $display("[TB] FAIL full_ackcode got %h exp 0010", ifA.cl_ackcode); end
   endtask

   task automatic test_reset_mid();
      applyStimulus(3'b000, 1'b1);
      tick();
      reset = 1'b1;
      applyStimulus(3'b111, 1'b1);
      checks++; if (ifA.cl_requestacpt !== 3'b000) begin errors++; $display("[TB] FAIL rmid_acpt got %b exp 000", ifA.cl_requestacpt); end
      tick();
      reset = 1'b0;
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.reqcnt !== 3'd0) begin errors++; $display("[TB] FAIL rmid_reqcnt got %0d exp 0", ifA.reqcnt); end
      checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL rmid_ack got %b exp 000", ifA.cl_ack); end
      checks++; if (ifA.cl_ackcode !== 16'h0000) begin errors++; $display("[TB] FAIL rmid_ackcode got %h exp 0000", ifA.cl_ackcode); end
      tick();
      checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL rmid_ack_late got %b exp 000", ifA.cl_ack); end
   endtask

   task automatic test_owner_routing();
      ifA.cl_requestcode = {16'h0000, 16'h0800, 16'h0806};
      ifA.cl_txsrc       = {8'hC2, 8'hB1, 8'hA0};
      applyStimulus(3'b010, 1'b0);
      checks++; if (ifA.cl_requestacpt !== 3'b010) begin errors++; $display("[TB] FAIL own_acpt1 got %b exp 010", ifA.cl_requestacpt); end
      tick();
      applyStimulus(3'b001, 1'b0);
      tick();
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.up_txdst !== 8'hA0) begin errors++; $display("[TB] FAIL own_tx0 got %h exp a0", ifA.up_txdst); end
      applyStimulus(3'b000, 1'b1);
      tick();
      tick();
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.cl_ack !== 3'b010) begin errors++; $display("[TB] FAIL own_ack1 got %b exp 010", ifA.cl_ack); end
      checks++; if (ifA.up_ackcode !== 16'h0800) begin errors++; $display("[TB] FAIL own_code1 got %h exp 0800", ifA.up_ackcode); end
      checks++; if (ifA.up_txdst !== 8'hB1) begin errors++; $display("[TB] FAIL own_tx1 got %h exp b1", ifA.up_txdst); end
      tick();
      checks++; if (ifA.cl_ack !== 3'b001) begin errors++; $display("[TB] FAIL own_ack0 got %b exp 001", ifA.cl_ack); end
      checks++; if (ifA.cl_ackcode !== 16'h0806) begin errors++; $display("[TB] FAIL own_code0 got %h exp 0806", ifA.cl_ackcode); end
      checks++; if (ifA.up_txdst !== 8'hA0) begin errors++; $display("[TB] FAIL own_tx2 got %h exp a0", ifA.up_txdst); end
      tick();
      checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL own_ack_end got %b exp 000", ifA.cl_ack); end
      checks++; if (ifA.cl_ackcode !== 16'h0806) begin errors++; $display("[TB] FAIL own_code_hold got %h exp 0806", ifA.cl_ackcode); end
   endtask

   task automatic test_overflow();
      checks++; if (ifA.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pre got %b exp 0", ifA.ovf_err); end
      applyStimulus(3'b000, 1'b1);
      tick();
      applyStimulus(3'b000, 1'b0);
      checks++; if (ifA.ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b exp 1", ifA.ovf_err); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ifA.cl_ack !== 3'b000) begin errors++; $display("[TB] FAIL ovf_noack%0d got %b exp 000", i, ifA.cl_ack); end
      end
      checks++; if (ifA.ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b exp 1", ifA.ovf_err); end
      checks++; if (ifA.reqcnt !== 3'd0) begin errors++; $display("[TB] FAIL ovf_reqcnt got %0d exp 0", ifA.reqcnt); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (ifA.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b exp 0", ifA.ovf_err); end
   endtask

   initial begin
      reset              = 1'b1;
      ifA.cl_request     = '0;
      ifA.cl_requestcode = '0;
      ifA.cl_txsrc       = '0;
      ifA.up_ack         = 1'b0;
      ifB.cl_request     = '0;
      ifB.cl_requestcode = '0;
      ifB.cl_txsrc       = '0;
      ifB.up_ack         = 1'b0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_full();
      test_reset_mid();
      test_owner_routing();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
